iguana_reg_watchdog: RTL and testbench

//  Register-bus guard between Cheshire's external reg port (HyperBus slot) and the HyperBus config slave.

---
 rtl/iguana_pkg.sv | 29 ++
 rtl/iguana_reg_watchdog.sv | 176 +++++++++++++++++
 tb/tb_iguana_reg_watchdog.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iguana_pkg.sv
// Shared Iguana SoC definitions: HyperBus register-slot placement and regbus request/response types.
package iguana_pkg;

  localparam int unsigned IguanaRegAddrWidth = 48;
  localparam int unsigned IguanaRegDataWidth = 32;

  localparam logic [IguanaRegAddrWidth-1:0] RegOutHyperBusBase = 48'h0000_2000_2000;
  localparam logic [IguanaRegAddrWidth-1:0] RegOutHyperBusSize = 48'h0000_0000_1000;
  localparam int unsigned                   IguanaRegWdtTimeout = 256;

  typedef struct packed {
    logic [IguanaRegAddrWidth-1:0]   addr;
    logic                            write;
    logic [IguanaRegDataWidth-1:0]   wdata;
    logic [IguanaRegDataWidth/8-1:0] wstrb;
    logic                            valid;
  } iguana_reg_req_t;

  typedef struct packed {
    logic [IguanaRegDataWidth-1:0] rdata;
    logic                          error;
    logic                          ready;
  } iguana_reg_rsp_t;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/iguana_reg_watchdog.sv
// Regbus guard in front of the HyperBus config slave: decode errors for foreign or misaligned
// addresses, and a timeout answer plus downstream drain when the slave stalls.
module iguana_reg_watchdog
  import iguana_pkg::*;
#(
  parameter int unsigned          AddrWidth     = IguanaRegAddrWidth,
  parameter int unsigned          DataWidth     = IguanaRegDataWidth,
  parameter logic [AddrWidth-1:0] RegionBase    = RegOutHyperBusBase,
  parameter logic [AddrWidth-1:0] RegionSize    = RegOutHyperBusSize,
  parameter int unsigned          TimeoutCycles = IguanaRegWdtTimeout,
  parameter type                  reg_req_t     = iguana_reg_req_t,
  parameter type                  reg_rsp_t     = iguana_reg_rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  reg_req_t   slv_req_i,
  output reg_rsp_t   slv_rsp_o,
  output reg_req_t   mst_req_o,
  input  reg_rsp_t   mst_rsp_i,
  input  logic       clear_i,
  output logic       timeout_o,
  output logic       decerr_o,
  output logic [7:0] timeout_cnt_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEC_ERR = 2'd1,
    TO_RSP  = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  localparam int unsigned        WaitW     = $clog2(TimeoutCycles);
  localparam logic [WaitW-1:0]   WaitLast  = WaitW'(TimeoutCycles - 1);
  // One extra bit so a region ending at the top of the address space cannot wrap.
  localparam logic [AddrWidth:0] RegionLo  = {1'b0, RegionBase};
  localparam logic [AddrWidth:0] RegionEnd = {1'b0, RegionBase} + {1'b0, RegionSize};

  state_e           state_r;
  logic [WaitW-1:0] wait_cnt_r;
  reg_req_t         latched_r;
  logic             timeout_r;
  logic             decerr_r;
  logic             busy_r;
  logic [7:0]       timeout_cnt_r;
  logic [AddrWidth:0] addr_ext_s;
  logic             in_range_s;

  assign addr_ext_s = {1'b0, slv_req_i.addr};
  assign in_range_s = (addr_ext_s >= RegionLo) && (addr_ext_s < RegionEnd)
                      && word_aligned(slv_req_i.addr[1:0]);

  // Request/response steering: passthrough only in IDLE for in-range requests
  always_comb begin
    mst_req_o = '0;
    slv_rsp_o = '0;
    case (state_r)
      IDLE: begin
        if (slv_req_i.valid && in_range_s) begin
          mst_req_o = slv_req_i;
          slv_rsp_o = mst_rsp_i;
        end else begin
          mst_req_o = '0;
          slv_rsp_o = '0;
        end
      end
      DEC_ERR: begin
        slv_rsp_o.ready = 1'b1;
        slv_rsp_o.error = 1'b1;
        slv_rsp_o.rdata = {DataWidth{1'b0}};
      end
      TO_RSP: begin
        mst_req_o       = latched_r;
        mst_req_o.valid = 1'b1;
        slv_rsp_o.ready = 1'b1;
        slv_rsp_o.error = 1'b1;
        slv_rsp_o.rdata = {DataWidth{1'b0}};
      end
      DRAIN: begin
        mst_req_o       = latched_r;
        mst_req_o.valid = 1'b1;
      end
      default: begin
        mst_req_o = '0;
        slv_rsp_o = '0;
      end
    endcase
  end

  // Transfer sequencing, slave wait counting, request latch and status flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      wait_cnt_r <= '0;
      latched_r  <= '0;
      timeout_r  <= 1'b0;
      decerr_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      decerr_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (slv_req_i.valid && !in_range_s) begin
            state_r    <= DEC_ERR;
            decerr_r   <= 1'b1;
            busy_r     <= 1'b1;
            wait_cnt_r <= '0;
          end else if (slv_req_i.valid && !mst_rsp_i.ready) begin
            // A ready arriving in the last waiting cycle takes the branch below instead.
            if (wait_cnt_r == WaitLast) begin
              latched_r  <= slv_req_i;
              state_r    <= TO_RSP;
              timeout_r  <= 1'b1;
              busy_r     <= 1'b1;
              wait_cnt_r <= '0;
            end else begin
              wait_cnt_r <= wait_cnt_r + WaitW'(1);
              busy_r     <= 1'b0;
            end
          end else begin
            wait_cnt_r <= '0;
            busy_r     <= 1'b0;
          end
        end
        DEC_ERR: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        TO_RSP: begin
          if (mst_rsp_i.ready) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= DRAIN;
            busy_r  <= 1'b1;
          end
        end
        DRAIN: begin
          if (mst_rsp_i.ready) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= DRAIN;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          wait_cnt_r <= '0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Saturating timeout counter; a clear landing on a timeout keeps that timeout
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_cnt_r <= 8'd0;
    end else if (clear_i) begin
      timeout_cnt_r <= (state_r == TO_RSP) ? 8'd1 : 8'd0;
    end else if ((state_r == TO_RSP) && (timeout_cnt_r != 8'hFF)) begin
      timeout_cnt_r <= timeout_cnt_r + 8'd1;
    end else begin
      timeout_cnt_r <= timeout_cnt_r;
    end
  end

  assign timeout_o     = timeout_r;
  assign decerr_o      = decerr_r;
  assign busy_o        = busy_r;
  assign timeout_cnt_o = timeout_cnt_r;

endmodule

// File: tb/tb_iguana_reg_watchdog.sv
// Scoreboard bench for iguana_reg_watchdog with a 16-cycle timeout and a programmable slave model.
module tb_iguana_reg_watchdog;
  import iguana_pkg::*;

  localparam int unsigned TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  iguana_reg_req_t slv_req;
  iguana_reg_rsp_t slv_rsp;
  iguana_reg_req_t mst_req;
  iguana_reg_rsp_t mst_rsp;
  logic            clear;
  logic            timeout;
  logic            decerr;
  logic [7:0]      tcnt;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  iguana_reg_watchdog #(.TimeoutCycles(TO)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slv_req_i    (slv_req),
    .slv_rsp_o    (slv_rsp),
    .mst_req_o    (mst_req),
    .mst_rsp_i    (mst_rsp),
    .clear_i      (clear),
    .timeout_o    (timeout),
    .decerr_o     (decerr),
    .timeout_cnt_o(tcnt),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
    logic        to_pulse;
    logic        de_pulse;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Slave model: ready in the ready_at-th consecutive cycle of mst valid (0 = never)
  int          ready_at = 0;
  logic [31:0] slave_rdata = 32'h0;
  int          n_wait = 0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;

  initial forever begin
    @(negedge clk);
    prev_v = mst_req.valid;
    prev_r = mst_rsp.ready;
  end

  initial begin
    mst_rsp = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) n_wait = 0;
      else if (prev_v && !prev_r) n_wait++;
      else n_wait = 0;
      mst_rsp.ready = mst_req.valid && (ready_at != 0) && (n_wait + 1 == ready_at);
      mst_rsp.rdata = slave_rdata;
    end
  end

  // Monitor: pops the scoreboard on each upstream completion
  initial begin
    exp_t e;
    int   mon_wait;
    mon_wait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_wait = 0;
      end else if (slv_req.valid && slv_rsp.ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: actual=response required=none");
        end else begin
          e = sb.pop_front();
          check({e.name, "_rdata"},   64'(slv_rsp.rdata), 64'(e.rdata));
          check({e.name, "_error"},   64'(slv_rsp.error), 64'(e.error));
          check({e.name, "_timeout"}, 64'(timeout),       64'(e.to_pulse));
          check({e.name, "_decerr"},  64'(decerr),        64'(e.de_pulse));
          check({e.name, "_latency"}, 64'(mon_wait + 1),  64'(e.lat));
        end
        mon_wait = 0;
      end else if (slv_req.valid) begin
        mon_wait++;
      end else begin
        mon_wait = 0;
      end
    end
  end

  task automatic push_exp(input logic [31:0] rdata, input logic err, input logic to_p,
                          input logic de_p, input int lat, input string name);
    exp_t e;
    e.rdata = rdata; e.error = err; e.to_pulse = to_p; e.de_pulse = de_p;
    e.lat = lat; e.name = name;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the upstream handshake
  task automatic issue(input logic [47:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp_rdata, input logic exp_err,
                       input logic exp_to, input logic exp_de, input int exp_lat,
                       input int exp_mst, input string name, input logic clr_on_rsp);
    int mst_cycles;
    bit done;
    mst_cycles = 0;
    done = 1'b0;
    push_exp(exp_rdata, exp_err, exp_to, exp_de, exp_lat, name);
    slv_req.addr  = addr;
    slv_req.write = wr;
    slv_req.wdata = wdata;
    slv_req.wstrb = wstrb;
    slv_req.valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (mst_req.valid) mst_cycles++;
      if (slv_rsp.ready) begin
        done = 1'b1;
        if (clr_on_rsp) clear = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_handshake: actual=no response required=response within 200 cycles", name);
      if (sb.size() > 0) sb.delete(sb.size() - 1);
    end
    @(posedge clk);
    #1;
    slv_req.valid = 1'b0;
    clear = 1'b0;
    check({name, "_mst_cycles"}, 64'(mst_cycles), 64'(exp_mst));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int k;
    rst = 1'b1;
    slv_req = '0;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_slv_rsp",  64'(slv_rsp),       64'd0);
    check("reset_mst_valid", 64'(mst_req.valid), 64'd0);
    check("reset_pulses",   64'({timeout, decerr, busy}), 64'd0);
    check("reset_tcnt",     64'(tcnt),          64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: normal read, slave ready in cycle 3
    ready_at = 3; slave_rdata = 32'hCAFE_F00D;
    issue(48'h2000_2008, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 3, 3, "t1_read", 1'b0);

    // 2: decode errors at the region edges and for a misaligned address
    issue(48'h2000_3000, 1'b1, 32'h1111_2222, 4'hF, 32'h0, 1'b1, 1'b0, 1'b1, 2, 0, "t2_end", 1'b0);
    issue(48'h2000_2002, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 2, 0, "t2_misalign", 1'b0);
    issue(48'h2000_1FFC, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 2, 0, "t2_below", 1'b0);

    // 3: slave stalls until cycle 40; stalled follow-up request forwards afterwards
    ready_at = 40; slave_rdata = 32'hBEEF_0001;
    issue(48'h2000_2100, 1'b1, 32'h1234_5678, 4'b0101, 32'h0, 1'b1, 1'b1, 1'b0, 17, 17, "t3_timeout", 1'b0);
    push_exp(32'hBEEF_0001, 1'b0, 1'b0, 1'b0, 24, "t3_stalled");
    slv_req.addr = 48'h2000_2010; slv_req.write = 1'b0; slv_req.wdata = 32'h0;
    slv_req.wstrb = 4'h0; slv_req.valid = 1'b1;
    @(negedge clk);
    check("t3_drain_addr",  64'(mst_req.addr),  64'h2000_2100);
    check("t3_drain_wdata", 64'(mst_req.wdata), 64'h1234_5678);
    check("t3_drain_wstrb", 64'(mst_req.wstrb), 64'h5);
    check("t3_drain_valid", 64'(mst_req.valid), 64'd1);
    check("t3_drain_stall", 64'(slv_rsp.ready), 64'd0);
    check("t3_drain_busy",  64'(busy),          64'd1);
    check("t3_tcnt",        64'(tcnt),          64'd1);
    k = 18;
    while (!mst_rsp.ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t3_drain_end_cycle", 64'(k), 64'd40);
    @(posedge clk); #1;
    ready_at = 1;
    @(negedge clk);
    check("t3_fwd_addr",  64'(mst_req.addr),  64'h2000_2010);
    check("t3_fwd_valid", 64'(mst_req.valid), 64'd1);
    @(posedge clk); #1;
    slv_req.valid = 1'b0;

    // 4: ready in the 16th waiting cycle completes normally
    ready_at = 16; slave_rdata = 32'h0000_4444;
    issue(48'h2000_2FFC, 1'b0, 32'h0, 4'h0, 32'h0000_4444, 1'b0, 1'b0, 1'b0, 16, 16, "t4_edge", 1'b0);
    check("t4_tcnt", 64'(tcnt), 64'd1);

    // 5: clear, saturation after 256 timeouts, clear coinciding with a timeout
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("t5_clear_first", 64'(tcnt), 64'd0);
    ready_at = 17;
    for (int i = 0; i < 256; i++)
      issue(48'h2000_2200, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 17, 17, "t5_to", 1'b0);
    check("t5_saturated", 64'(tcnt), 64'd255);
    issue(48'h2000_2200, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 17, 17, "t5_to_clr", 1'b1);
    check("t5_clear_with_timeout", 64'(tcnt), 64'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("t5_clear_alone", 64'(tcnt), 64'd0);

    // 6: reset in DRAIN, then a normal read
    ready_at = 100;
    issue(48'h2000_2300, 1'b1, 32'hA5A5_0000, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0, 17, 17, "t6_timeout", 1'b0);
    @(negedge clk);
    check("t6_pre_busy", 64'(busy), 64'd1);
    check("t6_pre_tcnt", 64'(tcnt), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_mst_valid", 64'(mst_req.valid), 64'd0);
    check("t6_rst_busy",      64'(busy),          64'd0);
    check("t6_rst_tcnt",      64'(tcnt),          64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    ready_at = 2; slave_rdata = 32'h5A5A_A5A5;
    issue(48'h2000_2004, 1'b0, 32'h0, 4'h0, 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b0, 2, 2, "t6_post", 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
